pil_reg: RTL and testbench

- Priority interrupt level register stage for the NORD-10/S interrupt system, card 1058.
- Holds the PID (interrupt detect) and PIE (interrupt enable) registers and priority-encodes PID & PIE.
- Loads the current level PIL when the interrupt control stage asserts its PIL clock strobe PILKL.
- Sits directly downstream of the interrupt control logic; PIL/PVL/LVLCHG go on to the register-bank and microprogram sequencer.

---
 rtl/pil_reg.sv | 109 ++++++++++
 tb/tb_pil_reg.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pil_reg.sv
// Priority interrupt level register stage: PID/PIE registers, priority encoder and PIL/PVL tracking.
// Optional `INT_SYNC_EN adds a two-flop synchroniser on irq_set before it reaches PID.
module pil_reg #(
    parameter int unsigned  NLEVELS = 16,
    localparam int unsigned LW      = $clog2(NLEVELS)
) (
    input  logic               clk,
    input  logic               MCLN,
    input  logic               PILKL,
    input  logic               ION,
    input  logic [NLEVELS-1:0] irq_set,
    input  logic               pid_we,
    input  logic               pie_we,
    input  logic [NLEVELS-1:0] wdata,
    input  logic               pid_clr,
    output logic [LW-1:0]      PIL,
    output logic [LW-1:0]      PVL,
    output logic [NLEVELS-1:0] PID,
    output logic [NLEVELS-1:0] PIE,
    output logic               INTREQ,
    output logic               LVLCHG
);

    logic [NLEVELS-1:0] r_pid;
    logic [NLEVELS-1:0] r_pie;
    logic [LW-1:0]      r_pil;
    logic [LW-1:0]      r_pvl;
    logic               r_lvlchg;

    logic [NLEVELS-1:0] w_set_eff;
    logic [NLEVELS-1:0] w_masked;
    logic [NLEVELS-1:0] w_pid_base;
    logic [NLEVELS-1:0] w_clr_mask;
    logic [NLEVELS-1:0] w_pid_d;
    logic [LW-1:0]      w_hp;
    logic               w_pil_load;

`ifdef INT_SYNC_EN
    logic [NLEVELS-1:0] r_sync1;
    logic [NLEVELS-1:0] r_sync2;

    always_ff @(posedge clk or negedge MCLN) begin
        if (!MCLN) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_set;
            r_sync2 <= r_sync1;
        end
    end

    assign w_set_eff = r_sync2;
`else
    assign w_set_eff = irq_set;
`endif

    // Highest pending enabled level; level 0 and "none" both encode as 0.
    assign w_masked = r_pid & r_pie;

    always_comb begin
        w_hp = '0;
        for (int i = 0; i < NLEVELS; i++) begin
            if (w_masked[i]) begin
                w_hp = LW'(i);
            end
        end
    end

    // Set requests take precedence over both the write and the level clear.
    assign w_pid_base = pid_we ? wdata : r_pid;
    assign w_clr_mask = pid_clr ? (NLEVELS'(1) << r_pil) : '0;
    assign w_pid_d    = (w_pid_base & ~w_clr_mask) | w_set_eff;

    assign w_pil_load = PILKL & ION & (w_hp != r_pil);

    always_ff @(posedge clk or negedge MCLN) begin
        if (!MCLN) begin
            r_pid <= '0;
            r_pie <= '0;
        end else begin
            r_pid <= w_pid_d;
            if (pie_we) begin
                r_pie <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge MCLN) begin
        if (!MCLN) begin
            r_pil    <= '0;
            r_pvl    <= '0;
            r_lvlchg <= 1'b0;
        end else begin
            r_lvlchg <= w_pil_load;
            if (w_pil_load) begin
                r_pvl <= r_pil;
                r_pil <= w_hp;
            end
        end
    end

    assign PIL    = r_pil;
    assign PVL    = r_pvl;
    assign PID    = r_pid;
    assign PIE    = r_pie;
    assign LVLCHG = r_lvlchg;
    assign INTREQ = ION & (w_hp > r_pil);

endmodule

// File: tb/tb_pil_reg.sv
// Scoreboard bench for pil_reg: stimulus pushes model predictions, a monitor pops and compares.
// Honours `INT_SYNC_EN the same way the design does (set requests delayed by two extra edges).
module tb_pil_reg;

    logic        clk;
    logic        MCLN;
    logic        PILKL;
    logic        ION;
    logic [15:0] irq_set;
    logic        pid_we;
    logic        pie_we;
    logic [15:0] wdata;
    logic        pid_clr;
    logic [3:0]  PIL;
    logic [3:0]  PVL;
    logic [15:0] PID;
    logic [15:0] PIE;
    logic        INTREQ;
    logic        LVLCHG;

    pil_reg #(.NLEVELS(16)) dut (
        .clk     (clk),
        .MCLN    (MCLN),
        .PILKL   (PILKL),
        .ION     (ION),
        .irq_set (irq_set),
        .pid_we  (pid_we),
        .pie_we  (pie_we),
        .wdata   (wdata),
        .pid_clr (pid_clr),
        .PIL     (PIL),
        .PVL     (PVL),
        .PID     (PID),
        .PIE     (PIE),
        .INTREQ  (INTREQ),
        .LVLCHG  (LVLCHG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pid;
        logic [15:0] pie;
        logic [3:0]  pil;
        logic [3:0]  pvl;
        logic        intreq;
        logic        lvlchg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit   m_pid [16];
    bit   m_pie [16];
    int   m_pil;
    int   m_pvl;
    int   m_lvlchg;
    logic [15:0] m_hist[$];

    // Staged stimulus for the next cycle
    logic        s_pilkl, s_ion, s_pid_we, s_pie_we, s_pid_clr;
    logic [15:0] s_irq, s_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int highest_pending();
        for (int lvl = 15; lvl > 0; lvl--) begin
            if (m_pid[lvl] && m_pie[lvl]) return lvl;
        end
        return 0;
    endfunction

    function automatic logic [15:0] pack(input bit v [16]);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[k] = v[k];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            m_pid[k] = 0;
            m_pie[k] = 0;
        end
        m_pil = 0;
        m_pvl = 0;
        m_lvlchg = 0;
        m_hist.delete();
`ifdef INT_SYNC_EN
        m_hist.push_back(16'h0);
        m_hist.push_back(16'h0);
`endif
    endtask

    task automatic clear_stage();
        s_pilkl = 0; s_pid_we = 0; s_pie_we = 0; s_pid_clr = 0;
        s_irq = 16'h0; s_wdata = 16'h0;
    endtask

    // Apply staged inputs for one clock, predict post-edge state and push it.
    task automatic do_cycle();
        int          hp;
        logic [15:0] eff;
        exp_t        e;
        @(negedge clk);
        MCLN = 1'b1;
        PILKL = s_pilkl; ION = s_ion; irq_set = s_irq;
        pid_we = s_pid_we; pie_we = s_pie_we; wdata = s_wdata; pid_clr = s_pid_clr;

        hp = highest_pending();
        m_hist.push_back(s_irq);
        eff = m_hist.pop_front();
        for (int k = 0; k < 16; k++) begin
            bit b;
            b = s_pid_we ? s_wdata[k] : m_pid[k];
            if (s_pid_clr && k == m_pil) b = 0;
            if (eff[k]) b = 1;
            m_pid[k] = b;
            if (s_pie_we) m_pie[k] = s_wdata[k];
        end
        if (s_pilkl && s_ion && hp != m_pil) begin
            m_pvl = m_pil;
            m_pil = hp;
            m_lvlchg = 1;
        end else begin
            m_lvlchg = 0;
        end

        e.pid = pack(m_pid);
        e.pie = pack(m_pie);
        e.pil = 4'(m_pil);
        e.pvl = 4'(m_pvl);
        e.lvlchg = m_lvlchg[0];
        e.intreq = s_ion && (highest_pending() > m_pil);
        sb.push_back(e);
        clear_stage();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) do_cycle();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".PID"}, 32'(PID), 32'h0);
        chk({tag, ".PIE"}, 32'(PIE), 32'h0);
        chk({tag, ".PIL"}, 32'(PIL), 32'h0);
        chk({tag, ".PVL"}, 32'(PVL), 32'h0);
        chk({tag, ".INTREQ"}, 32'(INTREQ), 32'h0);
        chk({tag, ".LVLCHG"}, 32'(LVLCHG), 32'h0);
    endtask

    // Asserted at a negedge, released at the next applied cycle.
    task automatic do_reset();
        @(negedge clk);
        MCLN = 1'b0;
        irq_set = 16'hFFFF;
        #1;
        check_zero("midreset");
        model_reset();
    endtask

    // Monitor: every output sample after a clock edge is matched against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("PID", 32'(PID), 32'(e.pid));
                chk("PIE", 32'(PIE), 32'(e.pie));
                chk("PIL", 32'(PIL), 32'(e.pil));
                chk("PVL", 32'(PVL), 32'(e.pvl));
                chk("INTREQ", 32'(INTREQ), 32'(e.intreq));
                chk("LVLCHG", 32'(LVLCHG), 32'(e.lvlchg));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        MCLN = 1'b0; PILKL = 0; ION = 0; irq_set = 16'hFFFF;
        pid_we = 0; pie_we = 0; wdata = 16'h0; pid_clr = 0;
        model_reset();
        clear_stage();
        s_ion = 1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");

        // Basic raise to level 10
        s_pie_we = 1; s_wdata = 16'h0400; do_cycle();
        s_irq = 16'h0400; do_cycle();
        idle(3);
        s_pilkl = 1; do_cycle();
        idle(2);

        // Priority ordering and level drop after clear
        s_pie_we = 1; s_wdata = 16'hFFFF; do_cycle();
        s_irq = 16'h0008; do_cycle();
        s_irq = 16'h1000; do_cycle();
        s_irq = 16'h0020; do_cycle();
        idle(3);
        s_pilkl = 1; do_cycle();
        idle(1);
        s_pid_clr = 1; do_cycle();
        s_pilkl = 1; do_cycle();
        idle(2);

        // ION gating
        do_reset();
        s_ion = 0;
        s_pie_we = 1; s_wdata = 16'h0020; do_cycle();
        s_irq = 16'h0020; do_cycle();
        idle(3);
        s_pilkl = 1; do_cycle();
        idle(1);
        s_ion = 1;
        s_pilkl = 1; do_cycle();
        idle(2);

        // Set/clear and set/write collisions
        do_reset();
        s_pie_we = 1; s_wdata = 16'hFFFF; do_cycle();
        s_irq = 16'h0080; do_cycle();
        idle(3);
        s_pilkl = 1; do_cycle();
        idle(1);
        s_pid_clr = 1; s_irq = 16'h0080; do_cycle();
        idle(3);
        s_pid_we = 1; s_wdata = 16'h0000; s_irq = 16'h0004; do_cycle();
        idle(3);

        // Set latency on a single bit
        s_irq = 16'h0200; do_cycle();
        idle(4);

        // Randomised traffic with a mid-run reset
        s_pie_we = 1; s_wdata = 16'hFFFF; do_cycle();
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) do_reset();
            s_ion    = ($urandom_range(0, 7) != 0);
            s_pilkl  = $urandom_range(0, 1);
            s_irq    = ($urandom_range(0, 2) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            s_pid_clr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) begin
                s_pid_we = 1;
                s_wdata  = 16'($urandom);
            end else if ($urandom_range(0, 39) == 0) begin
                s_pie_we = 1;
                s_wdata  = 16'($urandom) | 16'h8421;
            end
            do_cycle();
        end

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
